// File: rtl/latched_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : latched_demux_pkg
// Brief    : Shared constants and helpers for the latched demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package latched_demux_pkg;

    // Packet-tracking FSM encoding
    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE   = 1'b0;
    localparam logic [STATE_W-1:0] ST_PACKET = 1'b1;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/latched_demux_if.sv
`default_nettype none
// ============================================================================
// Module   : latched_demux_if
// Brief    : Stream bundle for the latched demultiplexer: one input stream
//            and N_OUTPUTS output streams packed side by side.
// Revision : 1.0 - initial release
// ============================================================================
interface latched_demux_if
    import latched_demux_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N_OUTPUTS = 3
);

    logic [WIDTH-1:0]           s_tdata;
    logic                       s_tvalid;
    logic                       s_tready;
    logic                       s_tlast;
    logic [N_OUTPUTS*WIDTH-1:0] m_tdata;
    logic [N_OUTPUTS-1:0]       m_tvalid;
    logic [N_OUTPUTS-1:0]       m_tready;
    logic [N_OUTPUTS-1:0]       m_tlast;

    // Demux side: consumes the input stream, produces the output streams
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    // Environment side: produces the input stream, consumes the outputs
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );

endinterface
`default_nettype wire

// File: rtl/latched_demux.sv
`default_nettype none
// ============================================================================
// Module   : latched_demux
// Brief    : Packet-aware 1-to-N stream demultiplexer. The destination is
//            latched only between packets and each beat is carried through a
//            single shared output register. Beats aimed at a non-existent
//            output are consumed and counted.
// Revision : 1.0 - initial release
// ============================================================================
module latched_demux
    import latched_demux_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N_OUTPUTS = 3,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clken,
    input  logic [SEL_WIDTH-1:0] sel,
    latched_demux_if.slave       bus,
    output logic                 busy,
    output logic [31:0]          drop_count
);

    localparam logic [SEL_WIDTH:0] c_n_outputs = (SEL_WIDTH+1)'(N_OUTPUTS);

    logic [STATE_W-1:0]         r_state;
    logic [STATE_W-1:0]         w_state_nxt;
    logic [SEL_WIDTH-1:0]       r_sel;
    logic [WIDTH-1:0]           r_data;
    logic                       r_last;
    logic [SEL_WIDTH-1:0]       r_dest;
    logic                       r_out_valid;
    logic [31:0]                r_drop_count;

    logic [N_OUTPUTS-1:0]       w_valid_vec;
    logic [N_OUTPUTS-1:0]       w_last_vec;
    logic [N_OUTPUTS*WIDTH-1:0] w_tdata;
    logic                       w_out_fire;
    logic                       w_s_tready;
    logic                       w_accept;
    logic                       w_in_range;

    // The held beat leaves when its own destination is ready; a new beat may
    // enter in that same cycle, so the register never idles under full flow.
    assign w_out_fire = |(w_valid_vec & bus.m_tready);
    assign w_s_tready = !rst && (!r_out_valid || w_out_fire);
    assign w_accept   = bus.s_tvalid && w_s_tready;
    assign w_in_range = ({1'b0, r_sel} < c_n_outputs);

    assign bus.s_tready = w_s_tready;
    assign bus.m_tvalid = w_valid_vec;
    assign bus.m_tlast  = w_last_vec;
    assign bus.m_tdata  = w_tdata;
    assign busy         = (r_state == ST_PACKET);
    assign drop_count   = r_drop_count;

    // Fan the shared register out to every output; only the destination sees valid
    always_comb begin
        w_valid_vec = '0;
        w_last_vec  = '0;
        w_tdata     = '0;
        for (int k = 0; k < N_OUTPUTS; k++) begin
            w_valid_vec[k]             = r_out_valid && (r_dest == SEL_WIDTH'(k));
            w_last_vec[k]              = r_last && r_out_valid && (r_dest == SEL_WIDTH'(k));
            w_tdata[k*WIDTH +: WIDTH]  = r_data;
        end
    end

    // Packet state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a packet opens on a non-last beat and closes on its last beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !bus.s_tlast) begin
                    w_state_nxt = ST_PACKET;
                end
            end
            ST_PACKET: begin
                if (w_accept && bus.s_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Destination select is only re-latched between packets
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= '0;
        end else if (clken && (r_state == ST_IDLE)) begin
            r_sel <= sel;
        end
    end

    // Output register: load only on acceptance so a stalled beat stays frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_last      <= 1'b0;
            r_dest      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            if (w_in_range) begin
                r_data      <= bus.s_tdata;
                r_last      <= bus.s_tlast;
                r_dest      <= r_sel;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    // Count beats swallowed because their destination does not exist
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_accept && !w_in_range) begin
            r_drop_count <= sat_inc32(r_drop_count);
        end
    end

endmodule
`default_nettype wire

// File: doc/latched_demux.md
LATCHED_DEMUX -- requirements
Module: latched_demux

Interface
REQ-001 WIDTH, 32, data width in bits of each stream.
REQ-002 N_OUTPUTS, 3, number of output streams.
REQ-003 SEL_WIDTH, 2, width of the select input.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst  input  1  reset: synchronous and active-high.
REQ-006 clken  input  1  select-load enable.
REQ-007 sel  input  SEL_WIDTH  requested destination index.
REQ-008 s_tdata  input  WIDTH  input stream data.
REQ-009 s_tvalid  input  1  input beat valid.
REQ-010 s_tready  output  1  input beat accepted when s_tvalid and s_tready are both high.
REQ-011 s_tlast  input  1  last beat of packet.
REQ-012 m_tdata  output  N_OUTPUTS*WIDTH  output data; slice k sits at [k*WIDTH +: WIDTH].
REQ-013 m_tvalid  output  N_OUTPUTS  per-output valid.
REQ-014 m_tready  input  N_OUTPUTS  per-output ready.
REQ-015 m_tlast  output  N_OUTPUTS  per-output last.
REQ-016 busy  output  1  high while in state PACKET.
REQ-017 drop_count  output  32  number of beats discarded because the destination was out of range.

Function
REQ-018 sel_reg SHALL load sel on a clk edge only when clken=1 and state=IDLE; it is ignored in PACKET.
REQ-019 A beat accepted in a given cycle SHALL use the sel_reg value held before that edge; a sel_reg load applies from the next beat onward.
REQ-020 States SHALL be IDLE and PACKET.
- IDLE->PACKET on an accepted beat with s_tlast=0.
- PACKET->IDLE on an accepted beat with s_tlast=1.
- An accepted beat in IDLE with s_tlast=1 SHALL leave the state in IDLE.
REQ-021 Output stage: one shared register holding data, last, dest (a copy of sel_reg at acceptance) and out_valid.
REQ-022 Latency SHALL be 1 cycle from input acceptance to m_tvalid[dest].
REQ-023 m_tvalid[k] SHALL equal out_valid AND (dest==k); all other m_tvalid bits are 0.
REQ-024 Every m_tdata slice SHALL carry the registered data; every m_tlast bit SHALL equal the registered last gated by m_tvalid[k].
REQ-025 s_tready SHALL equal (NOT out_valid) OR m_tready[dest], giving full throughput of one beat per cycle when downstream is ready.
REQ-026 While m_tvalid[k]=1 and m_tready[k]=0, the registered data, last and dest SHALL remain stable.
REQ-027 If sel_reg >= N_OUTPUTS at acceptance, the beat SHALL be accepted.
- out_valid is not set.
- drop_count increments by 1, saturating at 2^32-1.
- s_tready stays governed by REQ-025.
- State transitions per REQ-020 still apply.
REQ-028 Simultaneous output handshake and input acceptance in one cycle SHALL replace the register contents with no bubble.
REQ-029 A change of sel_reg SHALL NOT alter dest of a beat already held in the output register.

Reset
REQ-030 With rst=1 at a clk edge, the following SHALL hold:
- sel_reg=0 and state=IDLE.
- out_valid=0, so all m_tvalid=0 and m_tlast=0.
- data register=0 and dest=0.
- drop_count=0 and busy=0.
REQ-031 s_tready SHALL be 0 while rst=1.
REQ-032 Reset mid-packet SHALL discard the held beat and return to IDLE, with no output beat emitted afterwards.

Structure
REQ-033 Constants for the state encoding (IDLE, PACKET) SHALL live in the shared package; parameters stay module-local.
REQ-034 The module SHALL be flat with no sub-module; the output register stage is inline.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Reset, then set sel=1 with clken=1 and send 4 beats 0xA0..0xA3, last on 0xA3, all m_tready=1 -> outputs appear on m_tvalid[1] only, 1-cycle latency, m_tlast[1] on 0xA3.
- Mid-packet sel=2 with clken=1, then complete the packet -> remaining beats stay on output 1; the next packet goes to output 2.
- Hold m_tready[0]=0 for 5 cycles with a beat pending -> s_tready=0 and data is stable; release -> beat delivered and the next beat is accepted in the same cycle.
- Set sel=3 with N_OUTPUTS=3 and send 3 beats -> no m_tvalid, drop_count=3, s_tready=1 throughout.
- Assert rst while in PACKET with a beat held -> next cycle out_valid=0, busy=0, sel_reg=0, drop_count=0.
- Drive clken=1 and the first beat in the same IDLE cycle with sel 0->2 -> that beat goes to output 0 and the following packet goes to output 2.
